// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive and transmit paths:
//   - default clock / line-rate constants
//   - calc_div(): clocks per oversample tick (integer divide, truncating)
//   - uart_state_t: receiver FSM state encoding (also exported on a debug port)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int CLK_FREQ_DEF  = 50_000_000;
    localparam int BAUD_RATE_DEF = 115200;
    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    // Clocks per oversample tick. Truncation makes the receiver run slightly
    // fast (defaults: 27 clocks, +0.47%), well inside the sampling margin.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        return clk_freq / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// -----------------------------------------------------------------------------
// uart_rx_core_if
// Output side of the UART receiver.
//   rx_data      received byte, stable while rx_valid=1
//   rx_valid     byte available, held until accepted
//   rx_ready     consumer ready
//   rx_frame_err 1-cycle pulse, stop bit sampled low
//   rx_overrun   1-cycle pulse, byte completed while holding register full
//
// Handshake: a byte transfers on every rising clock edge where rx_valid and
// rx_ready are both 1. Once raised, rx_valid stays high and rx_data stays
// constant until that transfer happens; rx_ready may change freely and
// does not depend on rx_valid.
// -----------------------------------------------------------------------------
interface uart_rx_core_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;

    // master: the receiver core
    modport master (
        output rx_data, rx_valid, rx_frame_err, rx_overrun,
        input  rx_ready
    );

    // slave: the consumer
    modport slave (
        input  rx_data, rx_valid, rx_frame_err, rx_overrun,
        output rx_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider producing a 1-cycle tick every DIV clocks.
//   clk      in   system clock
//   rst_n    in   async active-low reset
//   restart  in   synchronous restart: counter cleared, next tick DIV clocks later
//   tick     out  1-cycle pulse
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// 8N1 UART receiver, LSB first, with a one-entry valid/ready output.
//   CLOCK_50   in   system clock
//   RESET_N    in   async active-low reset
//   UART_RXD   in   serial line, idle high, asynchronous to CLOCK_50
//   rx         if   output handshake + error pulses (uart_rx_core_if.master)
//   dbg_state  out  current FSM state
// Each bit is split into OVERSAMPLE ticks; the bit value is the majority of
// the synchronised line at ticks OS/2-1, OS/2 and OS/2+1, decided on OS/2+1.
// -----------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = CLK_FREQ_DEF,
    parameter int BAUD_RATE  = BAUD_RATE_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  UART_RXD,
    uart_rx_core_if.master        rx,
    output uart_state_t           dbg_state
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

    uart_state_t   state, next_state;
    logic          sync1, rxd_s;
    logic          tick, restart;
    logic [TW-1:0] tick_idx;
    logic [2:0]    bit_idx;
    logic          smp0, smp1, maj;
    logic [7:0]    shreg;
    logic          tick_dec, tick_end;
    logic          byte_done, frame_err_set;

    logic [7:0]    data_q;
    logic          valid_q, frame_err_q, overrun_q;

    assign rx.rx_data      = data_q;
    assign rx.rx_valid     = valid_q;
    assign rx.rx_frame_err = frame_err_q;
    assign rx.rx_overrun   = overrun_q;
    assign dbg_state       = state;

    // Two-flop synchroniser; flops reset to the idle (high) line level.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= UART_RXD;
            rxd_s <= sync1;
        end
    end

    // Divider phase is aligned to the start edge; in BREAK it is held while
    // the line is low so the high-time measurement starts on the rising edge.
    assign restart = ((state == IDLE) || (state == BREAK)) && !rxd_s;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .restart (restart),
        .tick    (tick)
    );

    assign tick_dec = tick && (tick_idx == T_DEC);
    assign tick_end = tick && (tick_idx == T_END);
    assign maj      = (smp0 & smp1) | (smp0 & rxd_s) | (smp1 & rxd_s);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        byte_done     = 1'b0;
        frame_err_set = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_s) next_state = START;
            end
            START: begin
                if (tick_dec && maj) next_state = IDLE;   // glitch, not a start bit
                else if (tick_end)   next_state = DATA;
            end
            DATA: begin
                if (tick_end && (bit_idx == 3'd7)) next_state = STOP;
            end
            STOP: begin
                // Leave at mid stop bit so a fast sender's next start edge is seen.
                if (tick_dec) begin
                    if (maj) begin
                        byte_done  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        frame_err_set = 1'b1;
                        next_state    = BREAK;
                    end
                end
            end
            BREAK: begin
                // tick_idx is cleared while low, so this is a full high bit time.
                if (tick_end && rxd_s) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Bit timing, sampling and shift register.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            tick_idx <= '0;
            bit_idx  <= '0;
            smp0     <= 1'b1;
            smp1     <= 1'b1;
            shreg    <= '0;
        end else begin
            if ((next_state != state) || (state == IDLE) ||
                ((state == BREAK) && !rxd_s)) begin
                tick_idx <= '0;
            end else if (tick) begin
                tick_idx <= (tick_idx == T_END) ? '0 : tick_idx + 1'b1;
            end

            if (tick && (tick_idx == T_S0)) smp0 <= rxd_s;
            if (tick && (tick_idx == T_S1)) smp1 <= rxd_s;

            if (state == START) begin
                bit_idx <= '0;
            end else if ((state == DATA) && tick_end) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if ((state == DATA) && tick_dec) begin
                shreg <= {maj, shreg[7:1]};
            end
        end
    end

    // Output holding register. A byte completing in the same cycle as an
    // accept replaces the old one; otherwise a full register drops it.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_set;
            overrun_q   <= byte_done && valid_q && !rx.rx_ready;
            if (byte_done && (!valid_q || rx.rx_ready)) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (valid_q && rx.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule
